// File: rtl/vga_timing_pkg.sv
// VGA timing constants and coordinate types shared by the sync generator and pixel generators.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 @ 60 Hz timing
  localparam int DEF_HD = 640;
  localparam int DEF_HF = 16;
  localparam int DEF_HR = 96;
  localparam int DEF_HB = 48;
  localparam int DEF_VD = 480;
  localparam int DEF_VF = 10;
  localparam int DEF_VR = 2;
  localparam int DEF_VB = 33;

  localparam int H_TOTAL = DEF_HD + DEF_HF + DEF_HR + DEF_HB;
  localparam int V_TOTAL = DEF_VD + DEF_VF + DEF_VR + DEF_VB;

  // Inclusive sync-pulse windows for the default timing
  localparam int HS_START = DEF_HD + DEF_HF;
  localparam int HS_END   = HS_START + DEF_HR - 1;
  localparam int VS_START = DEF_VD + DEF_VF;
  localparam int VS_END   = VS_START + DEF_VR - 1;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  // True when coordinate c lies inside the inclusive range [lo, hi]
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Mod-N clock divider producing a one-clk pixel tick when the count reaches N-1.
// Latency: first tick N-1 clks after reset release; tick is a decode of the count register.
// Backpressure: none, free-running; tick held low while reset is high.
module vga_tick_div #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  if (N < 1) begin : g_bad_div
    $error("vga_tick_div: N must be at least 1");
  end

  // Divider count wraps from N-1 back to 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Gated by reset so N=1 does not tick while the counters are held in reset
  assign tick = ~reset & (cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel/line counters, registered active-low syncs, visible-area and frame decodes.
// Latency: syncs change on the same edge as the counters; video_on/p_tick/frame_end decode registers.
// Backpressure: none, free-running display timing.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int HD      = DEF_HD,
  parameter int HF      = DEF_HF,
  parameter int HR      = DEF_HR,
  parameter int HB      = DEF_HB,
  parameter int VD      = DEF_VD,
  parameter int VF      = DEF_VF,
  parameter int VR      = DEF_VR,
  parameter int VB      = DEF_VB,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               frame_end
);

  localparam int LINE_LEN    = HD + HF + HR + HB;
  localparam int FRAME_LINES = VD + VF + VR + VB;

  localparam coord_t H_LAST = coord_t'(LINE_LEN - 1);
  localparam coord_t V_LAST = coord_t'(FRAME_LINES - 1);
  localparam coord_t H_VIS  = coord_t'(HD);
  localparam coord_t V_VIS  = coord_t'(VD);

  localparam int HS_LO = HD + HF;
  localparam int HS_HI = HD + HF + HR - 1;
  localparam int VS_LO = VD + VF;
  localparam int VS_HI = VD + VF + VR - 1;

  if (LINE_LEN > COORD_MAX || FRAME_LINES > COORD_MAX) begin : g_bad_timing
    $error("vga_sync_gen: total line or frame length exceeds coordinate range");
  end

  coord_t h_count, v_count;
  coord_t h_next, v_next;
  sync_t  sync_q;

  vga_tick_div #(
    .N(CLK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .tick (p_tick)
  );

  // Next counter values: advance on tick, line wrap carries into the line counter
  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (p_tick) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        v_next = (v_count == V_LAST) ? coord_t'(0) : v_count + coord_t'(1);
      end else begin
        h_next = h_count + coord_t'(1);
      end
    end
  end

  // Counters and syncs; syncs decode the next counts so they move on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count      <= '0;
      v_count      <= '0;
      sync_q.hsync <= 1'b1;
      sync_q.vsync <= 1'b1;
    end else begin
      h_count      <= h_next;
      v_count      <= v_next;
      sync_q.hsync <= ~in_window(h_next, HS_LO, HS_HI);
      sync_q.vsync <= ~in_window(v_next, VS_LO, VS_HI);
    end
  end

  assign hsync     = sync_q.hsync;
  assign vsync     = sync_q.vsync;
  assign pix_x     = h_count;
  assign pix_y     = v_count;
  assign video_on  = ~reset & (h_count < H_VIS) & (v_count < V_VIS);
  assign frame_end = p_tick & (h_count == H_LAST) & (v_count == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, a mid-size timing, a tiny CLK_DIV=1 timing).
// Expected outputs come from a closed-form model: pixel index = (clks since release / div) mod frame size.
// Random reset pulses are injected on top of directed line, frame and mid-retrace scenarios.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [2:0] rst;

  logic       hs_a, vs_a, vo_a, pt_a, fe_a;
  logic [9:0] px_a, py_a;
  logic       hs_b, vs_b, vo_b, pt_b, fe_b;
  logic [9:0] px_b, py_b;
  logic       hs_c, vs_c, vo_c, pt_c, fe_c;
  logic [9:0] px_c, py_c;

  vga_sync_gen #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(rst[0]), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .p_tick(pt_a), .pix_x(px_a), .pix_y(py_a), .frame_end(fe_a));

  vga_sync_gen #(.HD(20), .HF(3), .HR(5), .HB(4), .VD(10), .VF(2), .VR(2), .VB(3),
                 .CLK_DIV(3)) dut_b (
    .clk(clk), .reset(rst[1]), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .p_tick(pt_b), .pix_x(px_b), .pix_y(py_b), .frame_end(fe_b));

  vga_sync_gen #(.HD(4), .HF(1), .HR(2), .HB(1), .VD(3), .VF(1), .VR(1), .VB(1),
                 .CLK_DIV(1)) dut_c (
    .clk(clk), .reset(rst[2]), .hsync(hs_c), .vsync(vs_c), .video_on(vo_c),
    .p_tick(pt_c), .pix_x(px_c), .pix_y(py_c), .frame_end(fe_c));

  // Output vector layout: [24]hsync [23]vsync [22]video_on [21]p_tick [20]frame_end [19:10]x [9:0]y
  logic [24:0] act [3];
  assign act[0] = {hs_a, vs_a, vo_a, pt_a, fe_a, px_a, py_a};
  assign act[1] = {hs_b, vs_b, vo_b, pt_b, fe_b, px_b, py_b};
  assign act[2] = {hs_c, vs_c, vo_c, pt_c, fe_c, px_c, py_c};

  localparam logic [24:0] RESET_VEC = {1'b1, 1'b1, 3'b000, 10'd0, 10'd0};

  int p_hd  [3] = '{640, 20, 4};
  int p_hf  [3] = '{16, 3, 1};
  int p_hr  [3] = '{96, 5, 2};
  int p_hb  [3] = '{48, 4, 1};
  int p_vd  [3] = '{480, 10, 3};
  int p_vf  [3] = '{10, 2, 1};
  int p_vr  [3] = '{2, 2, 1};
  int p_vb  [3] = '{33, 3, 1};
  int p_div [3] = '{2, 3, 1};

  int n [3];
  int checks = 0;
  int errors = 0;
  logic [24:0] exp_v;

  // Reference: outputs as a function of clk edges since reset release
  function automatic logic [24:0] model(int i, int cnt, bit in_rst);
    int ht, vt, p, x, y;
    bit pt, hs, vs, vo, fe;
    if (in_rst) return RESET_VEC;
    ht = p_hd[i] + p_hf[i] + p_hr[i] + p_hb[i];
    vt = p_vd[i] + p_vf[i] + p_vr[i] + p_vb[i];
    p  = (cnt / p_div[i]) % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    pt = (cnt % p_div[i]) == p_div[i] - 1;
    hs = !(x >= p_hd[i] + p_hf[i] && x < p_hd[i] + p_hf[i] + p_hr[i]);
    vs = !(y >= p_vd[i] + p_vf[i] && y < p_vd[i] + p_vf[i] + p_vr[i]);
    vo = (x < p_hd[i]) && (y < p_vd[i]);
    fe = pt && (x == ht - 1) && (y == vt - 1);
    return {hs, vs, vo, pt, fe, 10'(x), 10'(y)};
  endfunction

  // Advance one clk; inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) n[i] = rst[i] ? 0 : n[i] + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] ptmask;
    rst = 3'b111;
    repeat (5) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act[i] !== RESET_VEC) begin
          errors++;
          $display("FAIL reset_hold dut%0d got=%h want=%h", i, act[i], RESET_VEC);
        end
      end
    end
    rst = 3'b000;
    ptmask = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k <= 6) ptmask[k-1] = act[0][21];
      for (int i = 0; i < 3; i++) begin
        exp_v = model(i, n[i], rst[i]);
        checks++;
        if (act[i] !== exp_v) begin
          errors++;
          $display("FAIL reset_release dut%0d n=%0d got=%h want=%h", i, n[i], act[i], exp_v);
        end
      end
    end
    checks++;
    if (ptmask !== 6'b010101) begin
      errors++;
      $display("FAIL first_ticks got=%b want=010101", ptmask);
    end
  endtask

  task automatic test_line();
    int hs_ticks, first_hs_x, y1_at, x_at_y1;
    hs_ticks = 0; first_hs_x = -1; y1_at = -1; x_at_y1 = -1;
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    repeat (1700) begin
      step();
      exp_v = model(0, n[0], 1'b0);
      checks++;
      if (act[0] !== exp_v) begin
        errors++;
        $display("FAIL line_trace n=%0d got=%h want=%h", n[0], act[0], exp_v);
      end
      if (act[0][21] && !act[0][24]) hs_ticks++;
      if (!act[0][24] && first_hs_x < 0) first_hs_x = int'(act[0][19:10]);
      if (act[0][9:0] == 10'd1 && y1_at < 0) begin
        y1_at = n[0];
        x_at_y1 = int'(act[0][19:10]);
      end
    end
    checks++;
    if (hs_ticks != 96) begin
      errors++;
      $display("FAIL hsync_width got=%0d want=96", hs_ticks);
    end
    checks++;
    if (first_hs_x != 656) begin
      errors++;
      $display("FAIL hsync_start got=%0d want=656", first_hs_x);
    end
    checks++;
    if (y1_at != 1600 || x_at_y1 != 0) begin
      errors++;
      $display("FAIL line_period got n=%0d x=%0d want n=1600 x=0", y1_at, x_at_y1);
    end
  endtask

  task automatic test_frame();
    int vs_ticks, vo_ticks, fe_cnt, fe_first, fe_second;
    vs_ticks = 0; vo_ticks = 0; fe_cnt = 0; fe_first = -1; fe_second = -1;
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    repeat (2 * 1632 + 6) begin
      step();
      exp_v = model(1, n[1], 1'b0);
      checks++;
      if (act[1] !== exp_v) begin
        errors++;
        $display("FAIL frame_trace n=%0d got=%h want=%h", n[1], act[1], exp_v);
      end
      if (n[1] < 1632 && act[1][21] && !act[1][23]) vs_ticks++;
      if (n[1] < 1632 && act[1][21] && act[1][22]) vo_ticks++;
      if (act[1][20]) begin
        fe_cnt++;
        if (fe_cnt == 1) fe_first = n[1];
        if (fe_cnt == 2) fe_second = n[1];
      end
      if (n[1] == 1632) begin
        checks++;
        if (act[1][22] !== 1'b1 || act[1][19:0] !== 20'd0) begin
          errors++;
          $display("FAIL frame_restart got vo=%b xy=%h want vo=1 xy=0", act[1][22], act[1][19:0]);
        end
      end
    end
    checks++;
    if (vs_ticks != 64) begin
      errors++;
      $display("FAIL vsync_ticks got=%0d want=64", vs_ticks);
    end
    checks++;
    if (vo_ticks != 200) begin
      errors++;
      $display("FAIL video_ticks got=%0d want=200", vo_ticks);
    end
    checks++;
    if (fe_cnt != 2 || fe_first != 1631 || fe_second != 3263) begin
      errors++;
      $display("FAIL frame_end got cnt=%0d at %0d,%0d want cnt=2 at 1631,3263",
               fe_cnt, fe_first, fe_second);
    end
  endtask

  task automatic test_mid_retrace();
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    while (n[1] < 1228) begin
      step();
      exp_v = model(1, n[1], 1'b0);
      checks++;
      if (act[1] !== exp_v) begin
        errors++;
        $display("FAIL pre_retrace n=%0d got=%h want=%h", n[1], act[1], exp_v);
      end
    end
    checks++;
    if (act[1][24] !== 1'b0 || act[1][23] !== 1'b0) begin
      errors++;
      $display("FAIL in_retrace got hs=%b vs=%b want hs=0 vs=0", act[1][24], act[1][23]);
    end
    rst[1] = 1'b1;
    step();
    checks++;
    if (act[1] !== RESET_VEC) begin
      errors++;
      $display("FAIL retrace_reset got=%h want=%h", act[1], RESET_VEC);
    end
    rst[1] = 1'b0;
    repeat (12) begin
      step();
      exp_v = model(1, n[1], 1'b0);
      checks++;
      if (act[1] !== exp_v) begin
        errors++;
        $display("FAIL retrace_restart n=%0d got=%h want=%h", n[1], act[1], exp_v);
      end
    end
  endtask

  task automatic test_small();
    int pt_low, hs_ticks, vs_ticks, fe_cnt, fe_first, fe_second;
    pt_low = 0; hs_ticks = 0; vs_ticks = 0; fe_cnt = 0; fe_first = -1; fe_second = -1;
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    repeat (100) begin
      step();
      exp_v = model(2, n[2], 1'b0);
      checks++;
      if (act[2] !== exp_v) begin
        errors++;
        $display("FAIL small_trace n=%0d got=%h want=%h", n[2], act[2], exp_v);
      end
      if (act[2][21] !== 1'b1) pt_low++;
      if (n[2] < 48 && !act[2][24]) hs_ticks++;
      if (n[2] < 48 && !act[2][23]) vs_ticks++;
      if (act[2][20]) begin
        fe_cnt++;
        if (fe_cnt == 1) fe_first = n[2];
        if (fe_cnt == 2) fe_second = n[2];
      end
    end
    checks++;
    if (pt_low != 0) begin
      errors++;
      $display("FAIL small_ptick got low_cycles=%0d want=0", pt_low);
    end
    checks++;
    if (hs_ticks != 12 || vs_ticks != 8) begin
      errors++;
      $display("FAIL small_sync got hs=%0d vs=%0d want hs=12 vs=8", hs_ticks, vs_ticks);
    end
    checks++;
    if (fe_cnt != 2 || fe_first != 47 || fe_second != 95) begin
      errors++;
      $display("FAIL small_frame got cnt=%0d at %0d,%0d want cnt=2 at 47,95",
               fe_cnt, fe_first, fe_second);
    end
  endtask

  task automatic test_random_reset();
    int len, hold;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 400);
      repeat (len) begin
        step();
        for (int i = 0; i < 3; i++) begin
          exp_v = model(i, n[i], rst[i]);
          checks++;
          if (act[i] !== exp_v) begin
            errors++;
            $display("FAIL rand_run it=%0d dut%0d n=%0d got=%h want=%h", it, i, n[i], act[i], exp_v);
          end
        end
      end
      rst  = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        step();
        for (int i = 0; i < 3; i++) begin
          exp_v = model(i, n[i], rst[i]);
          checks++;
          if (act[i] !== exp_v) begin
            errors++;
            $display("FAIL rand_reset it=%0d dut%0d n=%0d got=%h want=%h", it, i, n[i], act[i], exp_v);
          end
        end
      end
      rst = 3'b000;
    end
  endtask

  initial begin
    rst = 3'b111;
    n   = '{0, 0, 0};
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_mid_retrace();
    test_small();
    test_random_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
